// File: rtl/pcap_framer_if.sv
// Avalon-ST frame sink bundle for the pcap capture stage.
// The master is the frame source; the slave is pcap_framer.
interface pcap_framer_if;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_sop;
  logic        st_eop;
  logic [1:0]  st_empty;
  logic        st_error;
  logic        st_ready;

  modport master (
    output st_data, st_valid, st_sop, st_eop, st_empty, st_error,
    input  st_ready
  );

  modport slave (
    input  st_data, st_valid, st_sop, st_eop, st_empty, st_error,
    output st_ready
  );
endinterface

// File: rtl/pcap_framer.sv
// Store-and-forward pcap framer: buffers up to SNAPLEN bytes per frame, then writes
// a 4-word record header plus payload into the capture FIFO and kicks wr_ctrl.
module pcap_framer #(
  parameter int SNAPLEN    = 256,
  parameter int FIFO_DEPTH = 512
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  pcap_framer_if.slave                  st,
  input  logic [31:0]                   seconds,
  input  logic [31:0]                   nanoseconds,
  output logic [31:0]                   fifo_data,
  output logic                          fifo_wrreq,
  input  logic [$clog2(FIFO_DEPTH)-1:0] usedw,
  input  logic                          wr_ctrl_rdy,
  output logic                          wr_ctrl,
  output logic [31:0]                   pkt_begin,
  output logic [31:0]                   pkt_end,
  output logic [31:0]                   pkt_cnt,
  output logic [31:0]                   drop_cnt
);

  localparam int WORDS = SNAPLEN / 4;
  localparam int AW    = $clog2(WORDS);
  localparam logic [AW:0] W_ONE   = (AW+1)'(1);
  localparam logic [AW:0] W_WORDS = (AW+1)'(WORDS);

  typedef enum logic [2:0] {IDLE, RECV, DROP, HDR, PAYLOAD, COMMIT} state_t;

  state_t      state;
  logic        ready_q;
  logic [15:0] byte_cnt;
  logic [AW:0] buf_idx;
  logic [AW:0] wcnt;
  logic [31:0] ts_sec, ts_nsec;
  logic [15:0] incl_q, orig_q;
  logic [AW:0] n_q;
  logic [31:0] buf_mem [WORDS];
  logic [31:0] rd_q;

  function automatic logic [15:0] sat_u16(input logic [16:0] s);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Zero the bytes past incl_len; the first byte of a word sits in [31:24].
  function automatic logic [31:0] mask_tail(input logic [31:0] w, input logic [1:0] rem);
    case (rem)
      2'd1:    return w & 32'hFF00_0000;
      2'd2:    return w & 32'hFFFF_0000;
      2'd3:    return w & 32'hFFFF_FF00;
      default: return w;
    endcase
  endfunction

  logic        accept, restart, capture, buf_we, eop_ok, eop_bad, last_word;
  logic [2:0]  beat_bytes;
  logic [15:0] cnt_base, cnt_new, incl_new, incl_rnd;
  logic [16:0] cnt_sum;
  logic [AW:0] n_new, wr_idx, wcnt_inc;
  logic [31:0] space, need;
  logic [1:0]  drop_inc;
  logic [AW-1:0] rd_addr;

  always_comb begin
    accept     = st.st_valid & ready_q;
    restart    = accept & st.st_sop & ((state == IDLE & enable) | state == RECV);
    capture    = accept & ((state == IDLE & st.st_sop & enable) | state == RECV);
    beat_bytes = st.st_eop ? (3'd4 - {1'b0, st.st_empty}) : 3'd4;
    cnt_base   = restart ? 16'd0 : byte_cnt;
    cnt_sum    = {1'b0, cnt_base} + 17'(beat_bytes);
    cnt_new    = sat_u16(cnt_sum);
    incl_new   = (cnt_new > 16'(SNAPLEN)) ? 16'(SNAPLEN) : cnt_new;
    incl_rnd   = incl_new + 16'd3;
    n_new      = incl_rnd[AW+2:2];
    space      = 32'(FIFO_DEPTH) - 32'(usedw);
    need       = 32'(n_new) + 32'd4;
    eop_ok     = capture & st.st_eop & ~st.st_error & (space >= need);
    eop_bad    = capture & st.st_eop & (st.st_error | (space < need));
    wr_idx     = restart ? '0 : buf_idx;
    buf_we     = capture & (wr_idx < W_WORDS);
    drop_inc   = {1'b0, restart & (state == RECV)} + {1'b0, eop_bad};
    wcnt_inc   = wcnt + W_ONE;
    last_word  = (wcnt == n_q - W_ONE);
    rd_addr    = (state == PAYLOAD) ? wcnt_inc[AW-1:0] : '0;
  end

  assign st.st_ready = ready_q;
  assign pkt_begin   = '0;

  // Frame buffer: synchronous read, one cycle ahead of the FIFO write
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[wr_idx[AW-1:0]] <= st.st_data;
    rd_q <= buf_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      ts_sec  <= seconds;
      ts_nsec <= nanoseconds;
    end
    if (capture & st.st_eop) begin
      orig_q <= cnt_new;
      incl_q <= incl_new;
      n_q    <= n_new;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ready_q    <= 1'b0;
      byte_cnt   <= '0;
      buf_idx    <= '0;
      wcnt       <= '0;
      fifo_data  <= '0;
      fifo_wrreq <= 1'b0;
      wr_ctrl    <= 1'b0;
      pkt_end    <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      fifo_wrreq <= 1'b0;
      wr_ctrl    <= 1'b0;
      if (capture) begin
        byte_cnt <= cnt_new;
        buf_idx  <= buf_we ? wr_idx + W_ONE : wr_idx;
      end
      if (drop_inc != 2'd0) drop_cnt <= drop_cnt + 32'(drop_inc);

      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept && st.st_sop && !st.st_eop) state <= enable ? RECV : DROP;
        end
        RECV: if (accept && st.st_eop) state <= IDLE;
        DROP: if (accept && st.st_eop) state <= IDLE;
        HDR: begin
          fifo_wrreq <= 1'b1;
          case (wcnt[1:0])
            2'd0:    fifo_data <= ts_nsec;
            2'd1:    fifo_data <= 32'(incl_q);
            default: fifo_data <= 32'(orig_q);
          endcase
          wcnt <= wcnt_inc;
          if (wcnt[1:0] == 2'd2) begin
            wcnt  <= '0;
            state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          fifo_wrreq <= 1'b1;
          fifo_data  <= last_word ? mask_tail(rd_q, incl_q[1:0]) : rd_q;
          wcnt       <= wcnt_inc;
          if (last_word) state <= COMMIT;
        end
        COMMIT: if (wr_ctrl_rdy) begin
          wr_ctrl <= 1'b1;
          pkt_end <= 32'(n_q) + 32'd4;
          pkt_cnt <= pkt_cnt + 32'd1;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Accepted frame: the timestamp seconds word leaves on the very next cycle
      if (eop_ok) begin
        state      <= HDR;
        ready_q    <= 1'b0;
        wcnt       <= '0;
        fifo_wrreq <= 1'b1;
        fifo_data  <= restart ? seconds : ts_sec;
      end
    end
  end

endmodule

// File: tb/tb_pcap_framer.sv
// Directed bench for pcap_framer: record contents, latency, drops, stall and reset abort.
module tb_pcap_framer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] seconds = '0, nanoseconds = '0;
  logic [31:0] fifo_data;
  logic        fifo_wrreq;
  logic [8:0]  usedw = '0;
  logic        wr_ctrl_rdy = 1'b0;
  logic        wr_ctrl;
  logic [31:0] pkt_begin, pkt_end, pkt_cnt, drop_cnt;

  pcap_framer_if st_if ();

  pcap_framer #(.SNAPLEN(256), .FIFO_DEPTH(512)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .st(st_if),
    .seconds(seconds), .nanoseconds(nanoseconds),
    .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq), .usedw(usedw),
    .wr_ctrl_rdy(wr_ctrl_rdy), .wr_ctrl(wr_ctrl),
    .pkt_begin(pkt_begin), .pkt_end(pkt_end),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wq[$];
  int          n_pulse = 0, pulse_cyc = -1, first_wr_cyc = -1, eop_cyc = 0;
  bit          first_seen = 0;
  logic [31:0] last_pkt_end = '0;

  always @(negedge clk) begin
    if (fifo_wrreq) begin
      if (!first_seen) begin
        first_seen   = 1;
        first_wr_cyc = cyc;
      end
      wq.push_back(fifo_data);
    end
    if (wr_ctrl) begin
      n_pulse++;
      pulse_cyc    = cyc;
      last_pkt_end = pkt_end;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int i);
    return {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
  endfunction

  task automatic clear_mon();
    wq.delete();
    n_pulse    = 0;
    pulse_cyc  = -1;
    first_seen = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame whose byte k carries value k mod 256; beats change on negedges.
  task automatic send_frame(input int nbytes, input bit err);
    int beats;
    int to;
    beats = (nbytes + 3) / 4;
    for (int b = 0; b < beats; b++) begin
      @(negedge clk);
      st_if.st_valid = 1'b1;
      st_if.st_sop   = (b == 0);
      st_if.st_eop   = (b == beats - 1);
      st_if.st_empty = (b == beats - 1) ? 2'(beats*4 - nbytes) : 2'd0;
      st_if.st_error = (b == beats - 1) ? err : 1'b0;
      st_if.st_data  = exp_word(b);
      to = 0;
      while (st_if.st_ready !== 1'b1 && to < 200) begin
        @(negedge clk);
        to++;
      end
      if (to >= 200) begin
        chk("ready_timeout", 32'd0, 32'd1);
        st_if.st_valid = 1'b0;
        return;
      end
      if (b == beats - 1) eop_cyc = cyc;
      @(posedge clk);
    end
    @(negedge clk);
    st_if.st_valid = 1'b0;
    st_if.st_sop   = 1'b0;
    st_if.st_eop   = 1'b0;
    st_if.st_error = 1'b0;
    nanoseconds    = nanoseconds + 32'd77;
  endtask

  task automatic check_rec(input string tag, input int nbytes, input int sec, input int nsec,
                           input bit timing);
    int incl, n, rem;
    logic [31:0] w;
    incl = (nbytes > 256) ? 256 : nbytes;
    n    = (incl + 3) / 4;
    rem  = incl % 4;
    chk({tag, "_words"}, wq.size(), 4 + n);
    if (wq.size() >= 4 + n) begin
      chk({tag, "_sec"},  wq[0], sec);
      chk({tag, "_nsec"}, wq[1], nsec);
      chk({tag, "_incl"}, wq[2], incl);
      chk({tag, "_orig"}, wq[3], nbytes);
      for (int i = 0; i < n; i++) begin
        w = exp_word(i);
        if (i == n - 1 && rem != 0) w = w & (32'hFFFF_FFFF << (8 * (4 - rem)));
        chk({tag, "_pay"}, wq[4 + i], w);
      end
    end
    chk({tag, "_pulses"}, n_pulse, 1);
    chk({tag, "_pkt_end"}, last_pkt_end, 4 + n);
    if (timing) begin
      chk({tag, "_wr_lat"}, first_wr_cyc - eop_cyc, 1);
      chk({tag, "_ctrl_lat"}, pulse_cyc - eop_cyc, 5 + n);
    end
  endtask

  bit stall_bad;
  int rise_cyc;

  initial begin
    st_if.st_valid = 1'b0; st_if.st_sop = 1'b0; st_if.st_eop = 1'b0;
    st_if.st_empty = 2'd0; st_if.st_error = 1'b0; st_if.st_data = '0;

    wait_cyc(3);
    chk("rst_ready", st_if.st_ready, 0);
    chk("rst_wrreq", fifo_wrreq, 0);
    chk("rst_wr_ctrl", wr_ctrl, 0);
    chk("rst_fifo_data", fifo_data, 0);
    chk("rst_pkt_end", pkt_end, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", st_if.st_ready, 1);
    chk("pkt_begin", pkt_begin, 0);

    enable = 1'b1; wr_ctrl_rdy = 1'b1;
    clear_mon(); seconds = 1; nanoseconds = 500;
    send_frame(64, 0); wait_cyc(30);
    check_rec("f64", 64, 1, 500, 1);
    chk("f64_pkt_cnt", pkt_cnt, 1);
    chk("f64_drop_cnt", drop_cnt, 0);

    clear_mon(); seconds = 7; nanoseconds = 9;
    send_frame(300, 0); wait_cyc(80);
    check_rec("f300", 300, 7, 9, 1);
    chk("f300_pkt_cnt", pkt_cnt, 2);

    clear_mon(); seconds = 8; nanoseconds = 100;
    send_frame(61, 0); wait_cyc(30);
    check_rec("f61", 61, 8, 100, 1);
    chk("f61_pkt_cnt", pkt_cnt, 3);

    clear_mon(); usedw = 9'd500;
    send_frame(64, 0); wait_cyc(30);
    chk("full_words", wq.size(), 0);
    chk("full_pulses", n_pulse, 0);
    chk("full_drop_cnt", drop_cnt, 1);
    usedw = 9'd0;
    send_frame(64, 1); wait_cyc(30);
    chk("err_words", wq.size(), 0);
    chk("err_pulses", n_pulse, 0);
    chk("err_drop_cnt", drop_cnt, 2);
    chk("err_pkt_cnt", pkt_cnt, 3);

    enable = 1'b0;
    send_frame(16, 0); wait_cyc(10);
    chk("dis_words", wq.size(), 0);
    chk("dis_drop_cnt", drop_cnt, 2);
    enable = 1'b1;

    clear_mon(); wr_ctrl_rdy = 1'b0; seconds = 3; nanoseconds = 4;
    send_frame(64, 0);
    stall_bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (st_if.st_ready !== 1'b0 || wr_ctrl !== 1'b0) stall_bad = 1;
    end
    chk("stall_ready_low", 32'(stall_bad), 0);
    chk("stall_no_pulse", n_pulse, 0);
    rise_cyc = cyc;
    wr_ctrl_rdy = 1'b1;
    wait_cyc(3);
    chk("stall_pulse_lat", pulse_cyc - rise_cyc, 1);
    check_rec("stall", 64, 3, 4, 0);
    chk("stall_pkt_cnt", pkt_cnt, 4);

    clear_mon(); seconds = 11; nanoseconds = 12;
    send_frame(64, 0);
    wait_cyc(6);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_wrreq", fifo_wrreq, 0);
    chk("mid_rst_wr_ctrl", wr_ctrl, 0);
    chk("mid_rst_fifo_data", fifo_data, 0);
    chk("mid_rst_pkt_end", pkt_end, 0);
    chk("mid_rst_pkt_cnt", pkt_cnt, 0);
    chk("mid_rst_drop_cnt", drop_cnt, 0);
    chk("mid_rst_ready", st_if.st_ready, 0);
    wait_cyc(2);
    reset_n = 1'b1;
    clear_mon();
    wait_cyc(2);
    chk("post_rst_no_pulse", n_pulse, 0);
    seconds = 5; nanoseconds = 6;
    send_frame(64, 0); wait_cyc(30);
    check_rec("post_rst", 64, 5, 6, 1);
    chk("post_rst_pkt_cnt", pkt_cnt, 1);
    chk("post_rst_drop_cnt", drop_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
